// File: rtl/noc_pkg.sv
// noc_pkg: shared link constants and the credit-counter width helper.
package noc_pkg;
  localparam int FLIT_W = 8;
  localparam int VC_NUM = 2;
  localparam logic [FLIT_W-1:0] IDLE_FLIT = 8'h00;
  function automatic int cred_w(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-request round-robin arbiter with a registered last-grant pointer.
//   clk, rst (sync, active-low) | req[1:0] requests | en allows pointer update
//   gnt[1:0] one-hot grant (combinational) | ptr last granted index (reset 1)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);
  // On contention the requester not granted last wins.
  always_comb gnt = (&req) ? (ptr ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk)
    if (!rst) ptr <= 1'b1;
    else if (en && |gnt) ptr <= gnt[1];
endmodule

// File: rtl/vc_link_tx.sv
// vc_link_tx: two-VC credit-based flit link transmitter with round-robin arbitration.
//   clk, rst (sync, active-low)
//   in_valid_k / in_flit_k / in_ready_k : per-VC source handshake
//   credit_ret_k : one-cycle credit return pulse from downstream VC k
//   flit_out / vc_sel / flit_valid : registered link outputs (flit_out 0 when idle)
//   credit_k : current credit count of VC k | err : sticky protocol error
module vc_link_tx
  import noc_pkg::*;
#(
  parameter int CREDITS = 1,
  localparam int CW = cred_w(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic [FLIT_W-1:0] in_flit_0,
  input  logic [FLIT_W-1:0] in_flit_1,
  output logic              in_ready_0,
  output logic              in_ready_1,
  input  logic              credit_ret_0,
  input  logic              credit_ret_1,
  output logic [FLIT_W-1:0] flit_out,
  output logic              vc_sel,
  output logic              flit_valid,
  output logic [CW-1:0]     credit_0,
  output logic [CW-1:0]     credit_1,
  output logic              err
);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);
  logic [VC_NUM-1:0] valid, ready, xfer, load, zero, sat, eligible, grant, ret, hold_v;
  logic [VC_NUM-1:0][FLIT_W-1:0] flit_in, hold;
  logic [VC_NUM-1:0][CW-1:0] credit, credit_nxt;
  logic ptr_unused;
  assign valid      = {in_valid_1, in_valid_0};
  assign flit_in    = {in_flit_1, in_flit_0};
  assign ret        = {credit_ret_1, credit_ret_0};
  assign in_ready_0 = ready[0];
  assign in_ready_1 = ready[1];
  assign credit_0   = credit[0];
  assign credit_1   = credit[1];
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (eligible),
    .en  (1'b1),
    .gnt (grant),
    .ptr (ptr_unused)
  );
  // A granted hold register may reload in the same cycle, which keeps a
  // single VC streaming without bubbles.
  always_comb begin
    eligible   = '0;
    ready      = '0;
    xfer       = '0;
    load       = '0;
    zero       = '0;
    sat        = '0;
    credit_nxt = credit;
    for (int k = 0; k < VC_NUM; k++) begin
      eligible[k]   = hold_v[k] && credit[k] != '0;
      ready[k]      = !hold_v[k] || grant[k];
      xfer[k]       = valid[k] && ready[k];
      zero[k]       = xfer[k] && flit_in[k] == IDLE_FLIT;
      load[k]       = xfer[k] && flit_in[k] != IDLE_FLIT;
      sat[k]        = !grant[k] && ret[k] && credit[k] == CMAX;
      credit_nxt[k] = (grant[k] && !ret[k]) ? credit[k] - CW'(1) :
                      (!grant[k] && ret[k] && !sat[k]) ? credit[k] + CW'(1) : credit[k];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_v     <= '0;
      hold       <= '0;
      credit     <= {VC_NUM{CMAX}};
      flit_out   <= IDLE_FLIT;
      vc_sel     <= 1'b0;
      flit_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      for (int k = 0; k < VC_NUM; k++) begin
        if (load[k]) hold[k] <= flit_in[k];
        hold_v[k] <= load[k] || (hold_v[k] && !grant[k]);
      end
      credit     <= credit_nxt;
      flit_out   <= |grant ? hold[grant[1]] : IDLE_FLIT;
      vc_sel     <= |grant ? grant[1] : vc_sel;
      flit_valid <= |grant;
      err        <= err || |zero || |sat;
    end
  end
endmodule

// File: tb/tb_vc_link_tx.sv
// tb_vc_link_tx: directed bench for two vc_link_tx instances (CREDITS 1 and 4) against a behavioural model.
module tb_vc_link_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [1:0] iv0, iv1, cr0, cr1, rdy0, rdy1, vs, fv, er;
  logic [1:0][7:0] f0, f1, fo;
  logic [0:0] ca0, ca1;
  logic [2:0] cb0, cb1;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  vc_link_tx #(.CREDITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid_0(iv0[0]), .in_valid_1(iv1[0]),
    .in_flit_0(f0[0]), .in_flit_1(f1[0]), .in_ready_0(rdy0[0]), .in_ready_1(rdy1[0]),
    .credit_ret_0(cr0[0]), .credit_ret_1(cr1[0]), .flit_out(fo[0]), .vc_sel(vs[0]),
    .flit_valid(fv[0]), .credit_0(ca0), .credit_1(ca1), .err(er[0]));
  vc_link_tx #(.CREDITS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid_0(iv0[1]), .in_valid_1(iv1[1]),
    .in_flit_0(f0[1]), .in_flit_1(f1[1]), .in_ready_0(rdy0[1]), .in_ready_1(rdy1[1]),
    .credit_ret_0(cr0[1]), .credit_ret_1(cr1[1]), .flit_out(fo[1]), .vc_sel(vs[1]),
    .flit_valid(fv[1]), .credit_0(cb0), .credit_1(cb1), .err(er[1]));
  bit mhv[2][2];
  logic [7:0] mh[2][2];
  int mcr[2][2];
  int mlast[2];
  logic [7:0] mfo[2];
  int mvs[2];
  bit mfv[2], merr[2];
  function automatic int cmax(input int i);
    return i == 0 ? 1 : 4;
  endfunction
  function automatic bit inv(input int i, input int k);
    return k == 0 ? iv0[i] : iv1[i];
  endfunction
  function automatic logic [7:0] inf(input int i, input int k);
    return k == 0 ? f0[i] : f1[i];
  endfunction
  function automatic bit inret(input int i, input int k);
    return k == 0 ? cr0[i] : cr1[i];
  endfunction
  function automatic int dcred(input int i, input int k);
    if (i == 0) return k == 0 ? int'(ca0) : int'(ca1);
    return k == 0 ? int'(cb0) : int'(cb1);
  endfunction
  // Which VC the model sends this cycle, -1 when none.
  function automatic int winner(input int i);
    bit e0 = mhv[i][0] && mcr[i][0] > 0;
    bit e1 = mhv[i][1] && mcr[i][1] > 0;
    if (e0 && e1) return 1 - mlast[i];
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction
  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %0d want %0d", nm, i, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin
          mhv[i][k] = 0;
          mh[i][k]  = 8'h00;
          mcr[i][k] = cmax(i);
        end
        mlast[i] = 1;
        mfo[i]   = 8'h00;
        mvs[i]   = 0;
        mfv[i]   = 0;
        merr[i]  = 0;
      end else begin
        int w;
        logic [7:0] sent;
        w = winner(i);
        sent = 8'h00;
        if (w >= 0) sent = mh[i][w];
        for (int k = 0; k < 2; k++) begin
          bit take;
          take = inv(i, k) && (!mhv[i][k] || w == k);
          if (take && inf(i, k) == 8'h00) merr[i] = 1;
          if (take && inf(i, k) != 8'h00) begin
            mhv[i][k] = 1;
            mh[i][k]  = inf(i, k);
          end else if (w == k) mhv[i][k] = 0;
          mcr[i][k] = mcr[i][k] - (w == k ? 1 : 0) + (inret(i, k) ? 1 : 0);
          if (mcr[i][k] > cmax(i)) begin
            mcr[i][k] = cmax(i);
            merr[i]   = 1;
          end
        end
        if (w >= 0) begin
          mfo[i]   = sent;
          mvs[i]   = w;
          mfv[i]   = 1;
          mlast[i] = w;
        end else begin
          mfo[i] = 8'h00;
          mfv[i] = 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("flit_out", i, fo[i], mfo[i]);
        chk("vc_sel", i, vs[i], mvs[i]);
        chk("flit_valid", i, fv[i], mfv[i]);
        chk("err", i, er[i], merr[i]);
        chk("credit_0", i, dcred(i, 0), mcr[i][0]);
        chk("credit_1", i, dcred(i, 1), mcr[i][1]);
        chk("in_ready_0", i, rdy0[i], !mhv[i][0] || winner(i) == 0);
        chk("in_ready_1", i, rdy1[i], !mhv[i][1] || winner(i) == 1);
      end
    end
  end
  task automatic clr();
    iv0 = '0;
    iv1 = '0;
    cr0 = '0;
    cr1 = '0;
    f0  = '0;
    f1  = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    rst = 1'b0;
    clr();
    step();
    chk_en = 1;
    step();
    chk("rst_credit_a0", 0, ca0, 1);
    chk("rst_credit_b0", 1, cb0, 4);
    chk("rst_ready", 0, rdy0[0], 1);
    chk("rst_valid", 1, fv[1], 0);
    rst = 1'b1;
    // Single flit with one credit, then a second flit stalls.
    iv0[0] = 1'b1;
    f0[0]  = 8'hA5;
    step();
    clr();
    step();
    chk("t1_flit", 0, fo[0], 8'hA5);
    chk("t1_vc", 0, vs[0], 0);
    chk("t1_valid", 0, fv[0], 1);
    chk("t1_credit", 0, ca0, 0);
    iv0[0] = 1'b1;
    f0[0]  = 8'h5A;
    step();
    f0[0] = 8'h77;
    chk("t1_stall_ready", 0, rdy0[0], 0);
    step();
    chk("t1_stall_ready2", 0, rdy0[0], 0);
    chk("t1_stall_valid", 0, fv[0], 0);
    iv0[0] = 1'b0;
    cr0[0] = 1'b1;
    step();
    cr0[0] = 1'b0;
    step();
    chk("t1_resume_flit", 0, fo[0], 8'h5A);
    chk("t1_resume_credit", 0, ca0, 0);
    // Overflowing credit return saturates and sets err.
    cr0[0] = 1'b1;
    step();
    step();
    cr0[0] = 1'b0;
    chk("sat_credit", 0, ca0, 1);
    chk("sat_err", 0, er[0], 1);
    step();
    chk("sat_err_sticky", 0, er[0], 1);
    // Both VCs streaming with four credits alternate, VC0 first.
    iv0[1] = 1'b1;
    iv1[1] = 1'b1;
    f0[1]  = 8'h11;
    f1[1]  = 8'h22;
    step();
    chk("t2_first_idle", 1, fv[1], 0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("t2_flit", 1, fo[1], (j % 2) ? 8'h22 : 8'h11);
      chk("t2_vc", 1, vs[1], j % 2);
    end
    clr();
    step();
    step();
    step();
    chk("t2_credit0", 1, cb0, 1);
    chk("t2_credit1", 1, cb1, 1);
    chk("t2_idle", 1, fv[1], 0);
    // VC0 out of credit while VC1 streams with matching returns.
    iv0[1] = 1'b1;
    f0[1]  = 8'h33;
    step();
    clr();
    step();
    chk("t3_flit33", 1, fo[1], 8'h33);
    chk("t3_credit0", 1, cb0, 0);
    iv0[1] = 1'b1;
    f0[1]  = 8'h44;
    step();
    iv0[1] = 1'b0;
    iv1[1] = 1'b1;
    f1[1]  = 8'h55;
    cr1[1] = 1'b1;
    step();
    chk("t3_ret_credit1", 1, cb1, 2);
    for (int j = 0; j < 3; j++) begin
      step();
      chk("t3_flit55", 1, fo[1], 8'h55);
      chk("t3_vc1", 1, vs[1], 1);
      chk("t3_grant_ret_credit", 1, cb1, 2);
      chk("t3_vc0_blocked", 1, rdy0[1], 0);
    end
    cr0[1] = 1'b1;
    cr1[1] = 1'b0;
    iv1[1] = 1'b0;
    step();
    cr0[1] = 1'b0;
    chk("t3_edge_m_flit", 1, fo[1], 8'h55);
    step();
    chk("t3_flit44", 1, fo[1], 8'h44);
    chk("t3_vc0", 1, vs[1], 0);
    chk("t3_credit0_after", 1, cb0, 0);
    step();
    // Zero flit is swallowed and flagged.
    chk("zero_err_before", 1, er[1], 0);
    iv1[1] = 1'b1;
    f1[1]  = 8'h00;
    step();
    clr();
    chk("zero_err", 1, er[1], 1);
    chk("zero_not_held", 1, rdy1[1], 1);
    step();
    chk("zero_not_sent", 1, fv[1], 0);
    // Reset with both holds full.
    iv0[1] = 1'b1;
    iv1[1] = 1'b1;
    f0[1]  = 8'h66;
    f1[1]  = 8'h77;
    step();
    clr();
    rst = 1'b0;
    step();
    chk("mid_rst_flit", 1, fo[1], 0);
    chk("mid_rst_valid", 1, fv[1], 0);
    chk("mid_rst_credit0", 1, cb0, 4);
    chk("mid_rst_credit1", 1, cb1, 4);
    chk("mid_rst_ready1", 1, rdy1[1], 1);
    chk("mid_rst_err", 1, er[1], 0);
    chk("mid_rst_err_a", 0, er[0], 0);
    rst = 1'b1;
    step();
    chk("mid_rst_dropped", 1, fv[1], 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
